// File: rtl/norm_32_pkg.sv
// rtl/norm_32_pkg.sv - shared FPU package: default exponent width and pipeline records for norm_32
package norm_32_pkg;

  localparam int EXP_W_DEF = 10;

  // S1 record: operand captured on input transfer together with its leading-zero count
  typedef struct packed {
    logic                 valid;
    logic [31:0]          a;
    logic [EXP_W_DEF-1:0] e;
    logic [4:0]           c;
    logic                 v;
  } s1_rec_t;

  // S2 record: normalized result as presented to the rounding stage
  typedef struct packed {
    logic                 valid;
    logic [31:0]          m;
    logic [EXP_W_DEF-1:0] e;
    logic                 zero;
    logic                 denorm;
  } s2_rec_t;

endpackage

// File: rtl/norm_32_if.sv
// rtl/norm_32_if.sv - operand/result handshake bundle for norm_32
interface norm_32_if #(
  parameter int EXP_W = norm_32_pkg::EXP_W_DEF
);
  logic             valid_i;
  logic             ready_o;
  logic [31:0]      a;
  logic [EXP_W-1:0] e;
  logic             valid_o;
  logic             ready_i;
  logic [31:0]      m;
  logic [EXP_W-1:0] e_o;
  logic             zero;
  logic             denorm;

  modport master (
    output valid_i, a, e, ready_i,
    input  ready_o, valid_o, m, e_o, zero, denorm
  );

  modport slave (
    input  valid_i, a, e, ready_i,
    output ready_o, valid_o, m, e_o, zero, denorm
  );
endinterface

// File: rtl/norm_32_lzc.sv
// rtl/norm_32_lzc.sv - lzc_32: 32-bit leading-zero counter feeding the normalizer
module lzc_32 (
  input  logic [31:0] a,
  output logic [4:0]  c,
  output logic        v
);

  // Scan upward so the highest set bit writes last and wins; all-zero input yields c = 0, v = 0
  always_comb begin
    c = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) c = 5'(31 - i);
    end
    v = |a;
  end

endmodule

// File: rtl/norm_32.sv
// rtl/norm_32.sv - two-stage mantissa normalizer; optional exponent clamp under NORM_CLAMP_EN
module norm_32
  import norm_32_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF
) (
  input logic     clock,
  input logic     reset,
  norm_32_if.slave bus
);

  // Pipeline records are sized from EXP_W_DEF; EXP_W is expected to keep that value.
  s1_rec_t          s1;
  s2_rec_t          s2;
  logic [4:0]       lz_c;
  logic             lz_v;
  logic             s2_adv;
  logic             ready;
  logic [EXP_W-1:0] c_ext;
  logic [EXP_W-1:0] sh;
  logic [31:0]      n_m;
  logic [EXP_W-1:0] n_e;
  logic             n_denorm;

  lzc_32 u_lzc (
    .a (bus.a),
    .c (lz_c),
    .v (lz_v)
  );

  // S2 may take a new value when it is empty or its result leaves this cycle
  assign s2_adv = ~s2.valid | bus.ready_i;
  assign ready  = ~s1.valid | s2_adv;

  // Stage 1 capture: when ready, S1 is empty or moving into S2, so it simply follows valid_i
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
    end else if (ready) begin
      s1.valid <= bus.valid_i;
      if (bus.valid_i) begin
        s1.a <= bus.a;
        s1.e <= bus.e;
        s1.c <= lz_c;
        s1.v <= lz_v;
      end
    end
  end

  // Stage 2 datapath: shift amount, exponent adjustment and subnormal flag
  always_comb begin
    c_ext = {{(EXP_W-5){1'b0}}, s1.c};
`ifdef NORM_CLAMP_EN
    sh       = (c_ext <= s1.e) ? c_ext : s1.e;
    n_e      = s1.e - sh;
    n_denorm = s1.v & (sh < c_ext);
`else
    sh       = c_ext;
    n_denorm = s1.v & (c_ext > s1.e);
    n_e      = n_denorm ? '0 : s1.e - sh;
`endif
    n_m = s1.a << sh;
    if (!s1.v) begin
      n_m      = '0;
      n_e      = '0;
      n_denorm = 1'b0;
    end
  end

  // Stage 2 register: loads only when advancing, so a stalled result stays put
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2 <= '0;
    end else if (s2_adv) begin
      s2.valid <= s1.valid;
      if (s1.valid) begin
        s2.m      <= n_m;
        s2.e      <= n_e;
        s2.zero   <= ~s1.v;
        s2.denorm <= n_denorm;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = s2.valid;
  assign bus.m       = s2.m;
  assign bus.e_o     = s2.e;
  assign bus.zero    = s2.zero;
  assign bus.denorm  = s2.denorm;

endmodule

// File: tb/tb_norm_32.sv
// tb/tb_norm_32.sv - self-checking bench for norm_32 with a reference scoreboard
module tb_norm_32;

  typedef struct {
    logic [31:0] m;
    int          e;
    bit          z;
    bit          d;
    int          acc;
  } exp_t;

  logic clock;
  logic reset;
  norm_32_if #(.EXP_W(10)) bus ();

  norm_32 #(.EXP_W(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   chk_lat = 0;
  exp_t q[$];
  bit          held = 0;
  logic [31:0] held_m;
  logic [9:0]  held_e;
  logic        held_z;
  logic        held_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] m, input int e, input bit z, input bit d);
    exp_t r;
    r.m = m; r.e = e; r.z = z; r.d = d; r.acc = 0;
    return r;
  endfunction

  // Normalize by repeated single-bit shifts, spending exponent as we go
  function automatic exp_t model(input logic [31:0] a, input int e);
    exp_t        r;
    int          n;
    logic [31:0] mm;
    r.acc = 0;
    if (a == 32'd0) return mk(32'd0, 0, 1'b1, 1'b0);
    mm = a;
    n  = 0;
`ifdef NORM_CLAMP_EN
    while (!mm[31] && n < e) begin mm = mm << 1; n++; end
    r.m = mm; r.e = e - n; r.d = !mm[31];
`else
    while (!mm[31]) begin mm = mm << 1; n++; end
    r.m = mm; r.d = (n > e); r.e = r.d ? 0 : e - n;
`endif
    r.z = 1'b0;
    return r;
  endfunction

  task automatic step(input bit vi, input logic [31:0] av, input int ev, input bit ri,
                      input exp_t want, output bit acc);
    exp_t x;
    bus.valid_i = vi;
    bus.a       = av;
    bus.e       = 10'(ev);
    bus.ready_i = ri;
    #1;
    if (held) begin
      check("hold_valid", 64'(bus.valid_o), 64'd1);
      check("hold_m", 64'(bus.m), 64'(held_m));
      check("hold_e_o", 64'(bus.e_o), 64'(held_e));
      check("hold_flags", {62'd0, bus.zero, bus.denorm}, {62'd0, held_z, held_d});
    end
    check("ready_o", 64'(bus.ready_o), 64'((q.size() < 2) || ri));
    if (bus.valid_o && ri) begin
      if (q.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        x = q.pop_front();
        check("m", 64'(bus.m), 64'(x.m));
        check("e_o", 64'(bus.e_o), 64'(x.e));
        check("zero", 64'(bus.zero), 64'(x.z));
        check("denorm", 64'(bus.denorm), 64'(x.d));
        if (chk_lat) check("latency", 64'(cyc - x.acc), 64'd2);
      end
    end
    held   = bus.valid_o && !ri;
    held_m = bus.m;
    held_e = bus.e_o;
    held_z = bus.zero;
    held_d = bus.denorm;
    acc = vi && bus.ready_o;
    if (acc) begin
      want.acc = cyc;
      q.push_back(want);
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 0, 1'b1, mk(0, 0, 0, 0), acc);
  endtask

  logic [31:0] bp_a[4];
  int          bp_e[4];

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] ra;
    int          re;
    reset       = 1'b0;
    bus.valid_i = 1'b0;
    bus.a       = '0;
    bus.e       = '0;
    bus.ready_i = 1'b0;
    #1;
    check("rst_valid_o", 64'(bus.valid_o), 64'd0);
    check("rst_ready_o", 64'(bus.ready_o), 64'd1);
    check("rst_m", 64'(bus.m), 64'd0);
    check("rst_e_o", 64'(bus.e_o), 64'd0);
    check("rst_flags", {62'd0, bus.zero, bus.denorm}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed cases back to back at full throughput
    chk_lat = 1;
    step(1, 32'h8000_0001, 100, 1, mk(32'h8000_0001, 100, 0, 0), acc);
    step(1, 32'h0000_0F00, 200, 1, mk(32'hF000_0000, 180, 0, 0), acc);
`ifdef NORM_CLAMP_EN
    step(1, 32'h0000_0001, 5, 1, mk(32'h0000_0020, 0, 0, 1), acc);
`else
    step(1, 32'h0000_0001, 5, 1, mk(32'h8000_0000, 0, 0, 1), acc);
`endif
    step(1, 32'h0000_0000, 77, 1, mk(32'h0000_0000, 0, 1, 0), acc);
    idle(3);
    check("directed_drained", 64'(q.size()), 64'd0);
    chk_lat = 0;

    // Backpressure: four operands, ready_i low for the first three cycles
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 32'h0001_0000 >> i;
      bp_e[i] = 300 + i;
    end
    idx = 0;
    for (int t = 0; t < 12; t++) begin
      if (idx < 4) step(1, bp_a[idx], bp_e[idx], t >= 3, model(bp_a[idx], bp_e[idx]), acc);
      else         step(0, 32'd0, 0, t >= 3, mk(0, 0, 0, 0), acc);
      if (acc) idx++;
    end
    check("bp_all_sent", 64'(idx), 64'd4);
    check("bp_drained", 64'(q.size()), 64'd0);

    // Reset with both stages full
    step(1, 32'h0000_1234, 50, 0, model(32'h0000_1234, 50), acc);
    step(1, 32'h0000_5678, 60, 0, model(32'h0000_5678, 60), acc);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_valid_o", 64'(bus.valid_o), 64'd0);
    check("midrst_ready_o", 64'(bus.ready_o), 64'd1);
    check("midrst_m", 64'(bus.m), 64'd0);
    q.delete();
    held = 0;
    bus.valid_i = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step(1, 32'h0040_0000, 400, 1, model(32'h0040_0000, 400), acc);
    idle(3);
    check("post_rst_drained", 64'(q.size()), 64'd0);

    // Randomized traffic against the reference model
    for (int t = 0; t < 400; t++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      re = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 1023));
      step($urandom_range(0, 3) != 0, ra, re, $urandom_range(0, 2) != 0, model(ra, re), acc);
    end
    for (int t = 0; t < 10 && q.size() > 0; t++) idle(1);
    check("final_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/norm_32.md
# norm_32

Pipelined 32-bit mantissa normalizer: the consumer of the leading-zero count produced by `lzc_32`. It takes an unnormalized mantissa plus biased exponent, and left-shifts the mantissa until bit 31 is set. It decrements the exponent by the shift amount and flags zero and denormal results. It sits between the FPU add/sub/fma datapath and the rounding stage, with a valid/ready handshake on both sides and throughput of one operand per cycle.

## Interface
- `EXP_W`, 10: exponent width (biased, unsigned).
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `valid_i` input 1: input operand valid.
- `ready_o` output 1: block can accept an operand this cycle.
- `a` input 32: unnormalized mantissa.
- `e` input EXP_W: biased exponent of `a`.
- `valid_o` output 1: result valid.
- `ready_i` input 1: downstream accepts result this cycle.
- `m` output 32: normalized mantissa.
- `e_o` output EXP_W: adjusted exponent.
- `zero` output 1: `a` was all zeros.
- `denorm` output 1: shift was limited by the exponent; the result is subnormal.

## Operation
- Stage 1 (S1):
  - Instantiate `lzc_32` on `a`, giving count `c` (5 bits) and `v` (nonzero).
  - On input transfer (`valid_i & ready_o`), register `a`, `e`, `c`, `v`.
- Stage 2 (S2):
  - Compute shift amount `sh`, then register:
    - `m = a << sh`
    - `e_o = e - sh`
    - `zero = ~v`
    - `denorm = v & (sh < c)`
  - Output registers drive the outputs directly.
- Shift rule, with `NORM_CLAMP_EN` defined: `sh = (c <= e) ? c : e` (zero-extended compare at EXP_W bits). `e_o` never wraps below 0.
- Zero operand: `m = 0`, `e_o = 0`, `zero = 1`, `denorm = 0`. The input `e` is ignored.
- Each stage holds a valid bit; a stage advances when the stage after it is empty or is draining this cycle:
  - S2 load enable: `s1_valid & (~s2_valid | ready_i)`.
  - `ready_o = ~s1_valid | ~s2_valid | ready_i`.
- A held result is stable: `m`, `e_o`, `zero`, `denorm` do not change while `valid_o & ~ready_i`.
- Simultaneous accept and drain in the same cycle is legal. There are no bubbles at full throughput.

## Timing
- Latency: 2 cycles from input transfer to `valid_o` when there is no backpressure.
- Throughput: 1 operand per cycle with `ready_i` held high.
- Reset (asynchronous assert, `reset = 0`):
  - `valid_o = 0`; S1 and S2 valid bits cleared.
  - `m = 0`, `e_o = 0`, `zero = 0`, `denorm = 0`.
  - `ready_o = 1` combinationally once reset is asserted.
- Reset mid-operation discards all in-flight operands; no partial result appears after release.
- Backpressure: with `ready_i = 0`, S2 holds its result and S1 can still fill; `ready_o` then falls. With both stages full, `ready_o = 0` until `ready_i = 1`.
- Full-buffer drain: when `ready_i` rises with both stages full, `ready_o = 1` in that same cycle.

## Configuration
- Macro: `NORM_CLAMP_EN`.
- Defined: exponent-limited shift as above. `denorm` reports clamping; `e_o` saturates at 0.
- Undefined:
  - Always `sh = c`; `m` always has bit 31 set for nonzero input.
  - `denorm` is set when `c > e`, and then `e_o` is forced to 0.

## Structure
- Shared FPU package holds:
  - A typedef for the S1 and S2 pipeline register records (valid, mantissa, exponent, count, flags).
  - The `EXP_W` default constant.
- One sub-module: the existing `lzc_32`, instantiated in S1. The barrel shift stays inline in S2.

## Test plan
- Zero-count pass: `a = 32'h8000_0001`, `e = 100`, `ready_i = 1` → two cycles later `m = 32'h8000_0001`, `e_o = 100`, `zero = 0`, `denorm = 0`.
- Normal shift: `a = 32'h0000_0F00`, `e = 200` → `m = 32'hF000_0000`, `e_o = 180`, `denorm = 0`.
- Clamp path (macro on): `a = 32'h0000_0001`, `e = 5` → `m = 32'h0000_0020`, `e_o = 0`, `denorm = 1`.
  - Macro off, same input → `m = 32'h8000_0000`, `e_o = 0`, `denorm = 1`.
- Zero operand: `a = 0`, `e = 77` → `m = 0`, `e_o = 0`, `zero = 1`.
- Backpressure: stream 4 operands with `ready_i` held low for 3 cycles → `ready_o` falls after 2 accepts; results then emerge in order, each stable while stalled, none lost or duplicated.
- Reset mid-stream: assert `reset` with both stages full → `valid_o = 0` immediately; after release, the first output is the first operand accepted after reset.
